reaction_ctrl: RTL and testbench

Round sequencer for the reaction timer. It generates a millisecond timebase from the system clock and waits a pseudo-random delay after `start`. It then lights the stimulus LED and counts milliseconds until `stop`. The block flags early presses and timeouts, and holds the result for the display/BCD path downstream.

---
 rtl/reaction_pkg.sv | 22 ++
 rtl/ms_tick_gen.sv | 28 ++
 rtl/reaction_ctrl.sv | 145 ++++++++++++++
 tb/tb_reaction_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer: FSM states, LFSR seed/taps, result width.
package reaction_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_STIM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1 feeds back bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam int TIME_W            = 14;
    localparam int DEFAULT_MAX_COUNT = 9999;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {^(v & LFSR_TAPS), v[15:1]};
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Clearable timebase: one-cycle tick every DIV cycles; clear restarts the period so
// the first tick lands DIV-1 cycles after the cycle following the clear.
module ms_tick_gen #(
    parameter int DIV = 100_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer round sequencer: random wait, stimulus LED, millisecond reaction count
// with early/timeout flags. All outputs registered; result holds until the next start.
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 1000,
    parameter int MIN_DELAY = 2000,
    parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic              stim_led,
    output logic [TIME_W-1:0] time_ms,
    output logic              busy,
    output logic              valid,
    output logic              early,
    output logic              timeout
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = $clog2(MIN_DELAY + 4096 + 1);
    localparam logic [TIME_W-1:0] TIME_LAST = TIME_W'(MAX_COUNT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       lfsr;
    logic [DW-1:0]     delay_cnt;
    logic [DW-1:0]     delay_nxt;
    logic              tick;
    logic              clear;
    logic              final_tick;
    logic              stim_nxt;
    logic              busy_nxt;
    logic              valid_nxt;
    logic              early_nxt;
    logic              timeout_nxt;
    logic [TIME_W-1:0] time_nxt;

    ms_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .tick  (tick)
    );

    assign final_tick = tick && (delay_cnt <= DW'(1));

    // The timebase restarts whenever a timed state (WAIT or STIM) is entered.
    assign clear = (state_nxt != state) &&
                   ((state_nxt == S_WAIT) || (state_nxt == S_STIM));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (stop)            state_nxt = S_DONE;
                else if (final_tick) state_nxt = S_STIM;
            end
            S_STIM: begin
                // The tick that would carry the count to MAX_COUNT ends the round.
                if (stop)                                  state_nxt = S_DONE;
                else if (tick && (time_ms == TIME_LAST))   state_nxt = S_DONE;
            end
            S_DONE: begin
                if (start) state_nxt = S_WAIT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        delay_nxt   = delay_cnt;
        time_nxt    = time_ms;
        valid_nxt   = valid;
        early_nxt   = early;
        timeout_nxt = timeout;
        stim_nxt    = (state_nxt == S_STIM);
        busy_nxt    = (state_nxt == S_WAIT) || (state_nxt == S_STIM);
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    delay_nxt   = DW'(MIN_DELAY) + DW'(lfsr[11:0]);
                    time_nxt    = '0;
                    valid_nxt   = 1'b0;
                    early_nxt   = 1'b0;
                    timeout_nxt = 1'b0;
                end
            end
            S_WAIT: begin
                if (stop) begin
                    early_nxt = 1'b1;
                end else if (tick) begin
                    delay_nxt = delay_cnt - DW'(1);
                end
            end
            S_STIM: begin
                if (stop) begin
                    valid_nxt = 1'b1;
                end else if (tick) begin
                    time_nxt    = time_ms + TIME_W'(1);
                    timeout_nxt = (time_ms == TIME_LAST);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr      <= LFSR_SEED;
            delay_cnt <= '0;
            stim_led  <= 1'b0;
            busy      <= 1'b0;
            time_ms   <= '0;
            valid     <= 1'b0;
            early     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            lfsr      <= lfsr_step(lfsr);
            delay_cnt <= delay_nxt;
            stim_led  <= stim_nxt;
            busy      <= busy_nxt;
            time_ms   <= time_nxt;
            valid     <= valid_nxt;
            early     <= early_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl at DIV=10, MIN_DELAY=2, MAX_COUNT=50: timing-based reference
// model compared every cycle, plus hand-computed scenario checks.
module tb_reaction_ctrl;

    localparam int DIV  = 10;
    localparam int MIND = 2;
    localparam int MAXC = 50;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic        stim_led;
    logic        busy;
    logic        valid;
    logic        early;
    logic        timeout;
    logic [13:0] time_ms;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    reaction_ctrl #(
        .CLK_HZ    (10_000),
        .TICK_HZ   (1000),
        .MIN_DELAY (MIND),
        .MAX_COUNT (MAXC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .stim_led (stim_led),
        .time_ms  (time_ms),
        .busy     (busy),
        .valid    (valid),
        .early    (early),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // Reference model: rounds described by the absolute cycle the LED must rise.
    typedef enum {P_IDLE, P_WAIT, P_STIM, P_DONE} phase_t;
    phase_t      ph      = P_IDLE;
    logic [15:0] m_lfsr  = 16'hACE1;
    int          stim_at = 0;
    int          e_time  = 0;
    bit          e_valid = 1'b0;
    bit          e_early = 1'b0;
    bit          e_tout  = 1'b0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    always @(posedge clk) begin : model
        int c;
        c = cyc;
        if (reset) begin
            ph = P_IDLE; e_time = 0; e_valid = 0; e_early = 0; e_tout = 0;
        end else begin
            case (ph)
                P_IDLE, P_DONE: if (start) begin
                    ph      = P_WAIT;
                    stim_at = c + 1 + (MIND + int'(m_lfsr[11:0])) * DIV;
                    e_time  = 0; e_valid = 0; e_early = 0; e_tout = 0;
                end
                P_WAIT: begin
                    if (stop) begin
                        ph = P_DONE; e_early = 1;
                    end else if (c + 1 == stim_at) begin
                        ph = P_STIM;
                    end
                end
                P_STIM: begin
                    if (stop) begin
                        ph = P_DONE; e_valid = 1; e_time = (c - stim_at) / DIV;
                    end else if ((c + 1 - stim_at) / DIV >= MAXC) begin
                        ph = P_DONE; e_tout = 1; e_time = MAXC;
                    end
                end
                default: ;
            endcase
            if (ph == P_STIM) e_time = (c + 1 - stim_at) / DIV;
        end
        m_lfsr = reset ? 16'hACE1 : lfsr_next(m_lfsr);
        cyc = c + 1;
    end

    always @(negedge clk) begin : compare
        logic [18:0] got;
        logic [18:0] exp;
        if (chk_en) begin
            got = {stim_led, busy, valid, early, timeout, time_ms};
            exp = {ph == P_STIM, (ph == P_WAIT) || (ph == P_STIM),
                   e_valid, e_early, e_tout, 14'(e_time)};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL cycle_compare cyc=%0d {led,busy,valid,early,tout,time} got=%h exp=%h",
                         cyc, got, exp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cyc=%0d)", name, got, exp, cyc);
        end
    endtask

    task automatic start_when_small(output int k, output int l);
        int n;
        n = 0;
        while (m_lfsr[11:0] >= 12'd32 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        k = cyc;
        l = int'(m_lfsr[11:0]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_rise(output int r);
        int n;
        n = 0;
        while (!stim_led && n < 1000) begin
            @(negedge clk);
            n++;
        end
        r = cyc;
        checks++;
        if (!stim_led) begin
            failures++;
            $display("FAIL stim_wait stim_led=%0b after %0d cycles, required 1", stim_led, n);
        end
    endtask

    initial begin : stim
        int k, l, r, n, highs;

        reset = 1'b1; start = 1'b1; stop = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_outputs", 32'({stim_led, busy, valid, early, timeout, time_ms}), 32'd0);
        check("reset_state", 32'(dut.state), 32'(reaction_pkg::S_IDLE));
        reset = 1'b0; start = 1'b0;
        check("lfsr_seed", 32'(dut.lfsr), 32'h0000ACE1);
        @(negedge clk);
        check("lfsr_step1", 32'(dut.lfsr), 32'h00005670);
        @(negedge clk);
        check("lfsr_step2", 32'(dut.lfsr), 32'h0000AB38);

        // stop in IDLE is ignored
        stop = 1'b1; @(negedge clk); stop = 1'b0; @(negedge clk);
        check("idle_stop_ignored", 32'(dut.state), 32'(reaction_pkg::S_IDLE));

        // Normal round: stop 73 cycles after the LED rises -> 7 ms
        start_when_small(k, l);
        wait_rise(r);
        check("stim_rise_cycle", 32'(r), 32'(k + 1 + (MIND + l) * DIV));
        repeat (73) @(negedge clk);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        check("normal_valid", 32'(valid), 32'd1);
        check("normal_time", 32'(time_ms), 32'd7);
        check("normal_led_busy", 32'({stim_led, busy, early, timeout}), 32'd0);
        stop = 1'b1; @(negedge clk); stop = 1'b0; @(negedge clk);
        check("done_stop_hold", 32'({valid, time_ms}), 32'({1'b1, 14'd7}));

        // Restart from DONE, then early press 5 cycles after start
        start_when_small(k, l);
        check("restart_cleared", 32'({valid, early, timeout, time_ms}), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        check("early_flag", 32'(early), 32'd1);
        check("early_time", 32'(time_ms), 32'd0);
        check("early_busy", 32'(busy), 32'd0);
        highs = 0;
        repeat (400) begin
            @(negedge clk);
            if (stim_led) highs++;
        end
        check("early_no_stim", 32'(highs), 32'd0);

        // Timeout, with a start pulse in WAIT that must be ignored
        start_when_small(k, l);
        @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_rise(r);
        n = 0;
        while (busy && n < 700) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycle", 32'(cyc), 32'(r + 500));
        check("timeout_flag", 32'({timeout, valid, early}), 32'b100);
        check("timeout_time", 32'(time_ms), 32'd50);
        repeat (30) @(negedge clk);
        check("timeout_hold", 32'(time_ms), 32'd50);

        // Tie: stop on the 5th STIM tick; start pulse in STIM ignored
        start_when_small(k, l);
        wait_rise(r);
        repeat (20) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (28) @(negedge clk);
        check("tie_before", 32'(time_ms), 32'd4);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        check("tie_time", 32'(time_ms), 32'd4);
        check("tie_valid", 32'(valid), 32'd1);

        // Reset during STIM
        start_when_small(k, l);
        wait_rise(r);
        repeat (20) @(negedge clk);
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        check("midreset_outputs", 32'({stim_led, busy, valid, early, timeout, time_ms}), 32'd0);
        check("midreset_state", 32'(dut.state), 32'(reaction_pkg::S_IDLE));
        check("midreset_lfsr", 32'(dut.lfsr), 32'h0000ACE1);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
